// File: rtl/digit_convert_sched.sv
// Shared round-robin scheduled binary-to-ASCII decimal converter (double dabble).
// Ports: clock/reset_n, req/number_in per requester, ack, busy, out_valid, out_id, digits.
module digit_convert_sched #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] number_in,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  busy,
    output logic                  out_valid,
    output logic [ID_W-1:0]       out_id,
    output logic [47:0]           digits
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t state, state_n;

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    grant;
    logic [31:0]        bin;
    logic [39:0]        bcd;
    logic [5:0]         cnt;

    logic               found;
    logic [ID_W-1:0]    sel;
    logic [31:0]        num_sel;
    logic [NUM_REQ-1:0] ack_n;
    logic [39:0]        bcd_adj;
    logic [39:0]        bcd_n;
    logic [31:0]        bin_n;
    logic [47:0]        digits_n;
    logic               last_shift;

    // Round-robin: search starts one past the last granted index.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] &&
                    (j == (int'(ptr) + i) % NUM_REQ)) begin
                    found = 1'b1;
                    sel   = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        num_sel = '0;
        ack_n   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (sel == ID_W'(j)) begin
                num_sel  = number_in[32*j +: 32];
                ack_n[j] = found;
            end
        end
    end

    // One double-dabble step: add-3 on nibbles >= 5, then shift.
    always_comb begin
        bcd_adj = '0;
        for (int k = 0; k < 10; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            else
                bcd_adj[4*k +: 4] = bcd[4*k +: 4];
        end
        bcd_n = {bcd_adj[38:0], bin[31]};
        bin_n = {bin[30:0], 1'b0};
    end

    // Only the six low BCD nibbles are shown; upper ones are dropped.
    always_comb begin
        digits_n = '0;
        for (int k = 0; k < 6; k++) begin
            digits_n[8*k +: 8] = 8'h30 + {4'h0, bcd_n[4*k +: 4]};
        end
    end

    assign last_shift = (state == CONV) && (cnt == 6'd31);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (found) state_n = CONV;
            CONV:    if (last_shift) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr    <= ID_W'(NUM_REQ - 1);
            grant  <= '0;
            bin    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            ack    <= '0;
            out_id <= '0;
            digits <= 48'h303030303030;
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant <= sel;
                        ptr   <= sel;
                        bin   <= num_sel;
                        bcd   <= '0;
                        cnt   <= '0;
                        ack   <= ack_n;
                    end
                end
                CONV: begin
                    bin <= bin_n;
                    bcd <= bcd_n;
                    cnt <= cnt + 6'd1;
                    if (last_shift) begin
                        digits <= digits_n;
                        out_id <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

endmodule
